// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler: op codes, FSM states and datapath width.
package alu_pkg;

    localparam int ALU_W = 16;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_NAND = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_DIV  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    function automatic logic [1:0] id_to_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last granted client.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       gnt_id
);

    logic       ptr_r;
    logic [1:0] grant_s;

    // grant selection: on a tie the client that is not the pointer wins
    always_comb begin
        grant_s = 2'b00;
        if (en) begin
            case (req)
                2'b01:   grant_s = 2'b01;
                2'b10:   grant_s = 2'b10;
                2'b11:   grant_s = ptr_r ? 2'b01 : 2'b10;
                default: grant_s = 2'b00;
            endcase
        end else begin
            grant_s = 2'b00;
        end
    end

    assign grant  = grant_s;
    assign gnt_id = grant_s[1];

    // pointer register, moves only when a grant is issued
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r <= 1'b1;
        end else if (grant_s != 2'b00) begin
            ptr_r <= grant_s[1];
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// Sequences one operation at a time from two clients through the shared
// registered ALU and returns the result with a divide-by-zero flag.
module alu_scheduler
    import alu_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0][2:0]     req_op,
    input  logic [1:0][W-1:0]   req_a,
    input  logic [1:0][W-1:0]   req_b,
    output logic [1:0]          resp_valid,
    input  logic [1:0]          resp_ready,
    output logic [W-1:0]        resp_data,
    output logic                resp_dz,
    output logic [W-1:0]        alu_a,
    output logic [W-1:0]        alu_b,
    output logic [2:0]          alu_sel,
    output logic                alu_clr,
    input  logic [W-1:0]        alu_result
);

    state_e         state_r, state_s;
    logic [1:0]     grant_s;
    logic           gnt_id_s;
    logic           arb_en_s;
    logic           hs_s;
    logic           id_r;
    logic [W-1:0]   alu_a_r, alu_b_r;
    logic [2:0]     alu_sel_r;
    logic           alu_clr_r;
    logic [1:0]     resp_valid_r;
    logic [W-1:0]   resp_data_r;
    logic           resp_dz_r;

    // Gating with rst keeps req_ready low while reset is held.
    assign arb_en_s = (state_r == ST_IDLE) && rst;
    assign hs_s     = |(resp_valid_r & resp_ready);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .en     (arb_en_s),
        .req    (req_valid),
        .grant  (grant_s),
        .gnt_id (gnt_id_s)
    );

    // next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  state_s = (grant_s != 2'b00) ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_s = ST_WAIT;
            ST_WAIT:  state_s = ST_RESP;
            ST_RESP:  state_s = hs_s ? ST_IDLE : ST_RESP;
            default:  state_s = ST_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // issue registers double as the ALU drive; they are zeroed whenever the FSM returns to IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_r         <= 1'b0;
            alu_a_r      <= {W{1'b0}};
            alu_b_r      <= {W{1'b0}};
            alu_sel_r    <= 3'd0;
            alu_clr_r    <= 1'b1;
            resp_valid_r <= 2'b00;
            resp_data_r  <= {W{1'b0}};
            resp_dz_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_s != 2'b00) begin
                        id_r      <= gnt_id_s;
                        alu_a_r   <= req_a[gnt_id_s];
                        alu_b_r   <= req_b[gnt_id_s];
                        alu_sel_r <= req_op[gnt_id_s];
                        alu_clr_r <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    alu_clr_r <= 1'b0;
                end
                ST_WAIT: begin
                    resp_data_r  <= alu_result;
                    resp_dz_r    <= (alu_sel_r == OP_DIV) && (alu_b_r == {W{1'b0}});
                    resp_valid_r <= id_to_onehot(id_r);
                    alu_clr_r    <= 1'b1;
                end
                ST_RESP: begin
                    if (hs_s) begin
                        resp_valid_r <= 2'b00;
                        alu_a_r      <= {W{1'b0}};
                        alu_b_r      <= {W{1'b0}};
                        alu_sel_r    <= 3'd0;
                    end
                end
                default: begin
                    resp_valid_r <= 2'b00;
                    alu_clr_r    <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = grant_s;
    assign resp_valid = resp_valid_r;
    assign resp_data  = resp_data_r;
    assign resp_dz    = resp_dz_r;
    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign alu_sel    = alu_sel_r;
    assign alu_clr    = alu_clr_r;

endmodule

// File: tb/tb_alu_scheduler.sv
// Scoreboard bench for alu_scheduler with a behavioural model of the shared registered ALU.
module tb_alu_scheduler;
    import alu_pkg::*;

    localparam int W = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [1:0]         req_valid = 2'b00;
    logic [1:0]         req_ready;
    logic [1:0][2:0]    req_op = '0;
    logic [1:0][W-1:0]  req_a = '0;
    logic [1:0][W-1:0]  req_b = '0;
    logic [1:0]         resp_valid;
    logic [1:0]         resp_ready = 2'b11;
    logic [W-1:0]       resp_data;
    logic               resp_dz;
    logic [W-1:0]       alu_a, alu_b;
    logic [2:0]         alu_sel;
    logic               alu_clr;
    logic [W-1:0]       alu_result = '0;

    typedef struct {
        int           cl;
        logic [W-1:0] data;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   rise_cyc[2];
    int   hs_cyc  = 0;
    logic [1:0] prev_rv = 2'b00;

    alu_scheduler #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_dz    (resp_dz),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_clr    (alu_clr),
        .alu_result (alu_result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // shared ALU: registered result, clear forces zero, DIV by zero yields zero
    always @(posedge clk) begin
        if (alu_clr) begin
            alu_result <= '0;
        end else begin
            case (alu_sel)
                3'd0:    alu_result <= alu_a & alu_b;
                3'd1:    alu_result <= ~(alu_a & alu_b);
                3'd2:    alu_result <= alu_a | alu_b;
                3'd3:    alu_result <= ~(alu_a | alu_b);
                3'd4:    alu_result <= alu_a ^ alu_b;
                3'd5:    alu_result <= ~(alu_a ^ alu_b);
                3'd6:    alu_result <= ~alu_a;
                default: alu_result <= (alu_b == '0) ? '0 : alu_a / alu_b;
            endcase
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // response monitor: pops the scoreboard on every handshake
    always @(negedge clk) begin
        exp_t       e;
        logic [1:0] mask;
        #1;
        if (rst) begin
            for (int c = 0; c < 2; c++)
                if (resp_valid[c] && !prev_rv[c]) rise_cyc[c] = cyc;
            if ((resp_valid & resp_ready) != 2'b00) begin
                hs_cyc = cyc;
                if (sb.size() == 0) begin
                    check_eq("unexpected_resp", {30'd0, resp_valid}, 32'd0);
                end else begin
                    e    = sb.pop_front();
                    mask = (e.cl == 1) ? 2'b10 : 2'b01;
                    check_eq("resp_client", {30'd0, resp_valid}, {30'd0, mask});
                    check_eq("resp_data", {16'd0, resp_data}, {16'd0, e.data});
                    check_eq("resp_dz", {31'd0, resp_dz}, {31'd0, e.dz});
                end
            end
            prev_rv = resp_valid;
        end else begin
            prev_rv = 2'b00;
        end
    end

    task automatic set_req(input int c, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        req_op[c]    = op;
        req_a[c]     = a;
        req_b[c]     = b;
        req_valid[c] = 1'b1;
    endtask

    task automatic push_exp(input int c, input logic [W-1:0] d, input logic dz);
        exp_t e;
        e.cl = c; e.data = d; e.dz = dz;
        sb.push_back(e);
    endtask

    task automatic wait_grant(input int c, output int gc);
        bit ok;
        ok = 1'b0;
        gc = -1;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (req_ready[c]) begin
                ok = 1'b1;
                gc = cyc;
                break;
            end
            @(negedge clk);
        end
        check_eq($sformatf("grant%0d", c), {31'd0, ok}, 32'd1);
        if (ok) begin
            @(posedge clk);
            #1;
            req_valid[c] = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        for (int k = 0; k < 60; k++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check_eq(tag, sb.size(), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_ready"}, {30'd0, req_ready}, 32'd0);
        check_eq({tag, "_resp_valid"}, {30'd0, resp_valid}, 32'd0);
        check_eq({tag, "_resp_data"}, {16'd0, resp_data}, 32'd0);
        check_eq({tag, "_resp_dz"}, {31'd0, resp_dz}, 32'd0);
        check_eq({tag, "_alu_a"}, {16'd0, alu_a}, 32'd0);
        check_eq({tag, "_alu_b"}, {16'd0, alu_b}, 32'd0);
        check_eq({tag, "_alu_sel"}, {29'd0, alu_sel}, 32'd0);
        check_eq({tag, "_alu_clr"}, {31'd0, alu_clr}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int g0, g1, g;
        int seen;
        logic [W-1:0] held;
        logic         held_dz;

        // reset with both clients requesting: req_ready must stay low
        req_valid = 2'b11;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("rst");
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b1;

        // simultaneous requests after reset: client 0 first, client 1 four cycles later
        @(negedge clk);
        set_req(0, OP_XOR, 16'h10A4, 16'h1184);
        set_req(1, OP_NOR, 16'h0000, 16'h0000);
        push_exp(0, 16'h0120, 1'b0);
        push_exp(1, 16'hFFFF, 1'b0);
        wait_grant(0, g0);
        wait_grant(1, g1);
        drain("drain_tie");
        check_eq("tie_grant_gap", g1 - g0, 32'd4);
        check_eq("tie_latency0", rise_cyc[0] - g0, 32'd3);

        // single client AND
        @(negedge clk);
        set_req(0, OP_AND, 16'h000C, 16'h000C);
        push_exp(0, 16'h000C, 1'b0);
        wait_grant(0, g);
        drain("drain_and");
        check_eq("and_latency", rise_cyc[0] - g, 32'd3);

        // divide by zero, then a normal divide
        @(negedge clk);
        set_req(1, OP_DIV, 16'h0064, 16'h0000);
        push_exp(1, 16'h0000, 1'b1);
        wait_grant(1, g);
        drain("drain_dz");
        @(negedge clk);
        set_req(1, OP_DIV, 16'h0064, 16'h0005);
        push_exp(1, 16'h0014, 1'b0);
        wait_grant(1, g);
        drain("drain_div");
        check_eq("div_latency", rise_cyc[1] - g, 32'd3);

        // back-pressure on client 0 while client 1 waits
        @(negedge clk);
        resp_ready = 2'b10;
        set_req(0, OP_OR, 16'h0F00, 16'h00F0);
        push_exp(0, 16'h0FF0, 1'b0);
        wait_grant(0, g);
        @(negedge clk);
        set_req(1, OP_NAND, 16'hFFFF, 16'h00FF);
        push_exp(1, 16'hFF00, 1'b0);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (resp_valid[0]) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check_eq("bp_resp_seen", seen, 32'd1);
        held    = resp_data;
        held_dz = resp_dz;
        check_eq("bp_held_data", {16'd0, held}, 32'h0000_0FF0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check_eq("bp_valid", {30'd0, resp_valid}, 32'd1);
            check_eq("bp_data", {16'd0, resp_data}, {16'd0, held});
            check_eq("bp_dz", {31'd0, resp_dz}, {31'd0, held_dz});
            check_eq("bp_ready1", {31'd0, req_ready[1]}, 32'd0);
        end
        @(negedge clk);
        resp_ready = 2'b11;
        wait_grant(1, g1);
        check_eq("bp_grant_after_hs", g1 - hs_cyc, 32'd1);
        drain("drain_bp");

        // reset in WAIT: no response, outputs at reset values immediately
        @(negedge clk);
        set_req(0, OP_XNOR, 16'h00FF, 16'h0F0F);
        push_exp(0, 16'hF00F, 1'b0);
        wait_grant(0, g);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b1;
        rst = 1'b0;
        sb.delete(sb.size() - 1);
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        req_valid = 2'b00;
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (resp_valid != 2'b00) seen++;
        end
        check_eq("midrst_no_resp", seen, 32'd0);

        @(negedge clk);
        set_req(1, OP_AND, 16'hFF00, 16'h0FF0);
        push_exp(1, 16'h0F00, 1'b0);
        wait_grant(1, g);
        drain("drain_after_rst");
        check_eq("after_rst_latency", rise_cyc[1] - g, 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Sequencer and two-requester arbiter for the shared 16-bit ALU (eight ops, one-cycle registered result). It accepts operations from two clients over valid/ready handshakes and grants them round-robin. It drives the ALU operand and select inputs, captures the registered ALU result, and returns it to the winning client with a divide-by-zero flag. Only one operation is in flight at a time.

## Interface
- W, 16, operand/result width; must match ALU width
- clk  in  1  rising-edge clock shared with the ALU accumulator
- rst  in  1  asynchronous, active-low reset
- req_valid  in  2  per-client request strobe
- req_ready  out  2  per-client accept; at most one bit high
- req_op  in  2x3  per-client ALU select code
- req_a, req_b  in  2xW  per-client operands
- resp_valid  out  2  per-client result strobe; at most one bit high
- resp_ready  in  2  per-client result accept
- resp_data  out  W  result for the client flagged in resp_valid
- resp_dz  out  1  qualified by resp_valid; set for DIV with B==0
- alu_a, alu_b  out  W  ALU operands
- alu_sel  out  3  ALU op select
- alu_clr  out  1  ALU active-high clear (forces ALU mux output to zero)
- alu_result  in  W  ALU accumulator output (registered inside ALU)

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any req_valid is high, pick a winner and raise req_ready[winner] combinationally.
  - At the edge, latch op, a, b and the winner id into the issue registers, then go to ISSUE.
  - If no request is pending, stay in IDLE.
- **ISSUE**
  - Drive alu_a, alu_b and alu_sel from the issue registers, with alu_clr=0.
  - The ALU registers the result at this edge. Go to WAIT.
- **WAIT**
  - alu_result is valid. Latch it into resp_data.
  - Compute resp_dz = (op==DIV && b==0), then go to RESP.
- **RESP**
  - Hold resp_valid[id]=1 until resp_ready[id]. While it is held, resp_data and resp_dz stay stable.
  - On the handshake, go to IDLE.
- **Arbitration**
  - A one-bit pointer records the last granted client.
  - If both clients request, the client that is not the pointer wins.
  - If only one client requests, that client wins.
  - The pointer updates only on a grant.
- **ALU outputs by state**
  - alu_clr=1 in IDLE and RESP, 0 in ISSUE and WAIT.
  - alu_a, alu_b and alu_sel hold the issue registers in every state except IDLE, where they are 0.
- **DIV with B==0**: the ALU returns 0. The scheduler passes 0 through and sets resp_dz=1.
- **Request rules**
  - A request stays held until req_ready.
  - Dropping req_valid before the grant is legal; that request is simply not served.
  - Requests are ignored outside IDLE; req_ready=0 there.

## Timing
- **Reset values** (asynchronous, while rst=0): state=IDLE; pointer=1, so client 0 wins the first tie. Outputs:
  - req_ready=0, resp_valid=0, resp_data=0, resp_dz=0
  - alu_a=0, alu_b=0, alu_sel=0, alu_clr=1
- **Latency**
  - Grant cycle N (IDLE) → ISSUE N+1 → WAIT N+2 → resp_valid high in N+3.
  - If resp_ready is already high in N+3, the next grant can occur in N+4. Peak throughput is one operation per 4 cycles.
- **Back-pressure**: a low resp_ready stalls the FSM in RESP indefinitely. The other client is not granted during the stall.
- **Reset mid-operation**: the in-flight operation is discarded with no response. After reset release, the FSM resumes in IDLE on the first edge.
- **Simultaneous events**: both req_valid rising on the same cycle as the RESP handshake are not granted that cycle. Arbitration happens on the following IDLE cycle.

## Structure
- A shared package, alu_pkg, holds:
  - op code constants: OP_AND=0, OP_NAND=1, OP_OR=2, OP_NOR=3, OP_XOR=4, OP_XNOR=5, OP_NOT=6, OP_DIV=7
  - the state enumeration
  - the width default of 16
- Sub-module rr_arb2 is a 2-way round-robin arbiter with a pointer register and a grant vector. Everything else stays in alu_scheduler.

## Test plan
- **Single client, AND**: client 0 sends op 0, a=0x000C, b=0x000C. Expect req_ready in cycle N, resp_valid[0] in N+3, resp_data=0x000C, resp_dz=0.
- **Simultaneous requests after reset**: client 0 sends XOR 0x10A4^0x1184; client 1 sends NOR 0,0.
  - Expect client 0 served first with 0x0120, then client 1 with 0xFFFF.
  - Client 1's grant comes 4 cycles after client 0's.
- **Divide by zero**: client 1 sends DIV a=0x0064, b=0. Expect resp_data=0, resp_dz=1. Then DIV 0x0064/0x0005 gives 0x0014, resp_dz=0.
- **Back-pressure**: hold resp_ready[0]=0 for 5 cycles with client 1 requesting.
  - resp_valid[0] and resp_data stay stable; req_ready[1] stays 0.
  - Client 1 is granted one cycle after the handshake.
- **Reset mid-operation**: assert rst=0 in WAIT. All outputs take their reset values immediately, and no resp_valid follows. The next request completes normally.
